edp_step_seq: RTL and testbench
===============================

# edp_step_seq

Synthesizable, parametrised micro-step sequencer that replays a programmable table of EBOX data-path steps (cache word, AD function, AR/BR load strobes, expected AD) into the EDP, then samples and checks the AD result of each step. It sits beside `edp` and lets hardware and simulation run the same directed EDP exercises as loadable step programs. It also supports repeat passes, settle-delay tuning, abort, and first-failure capture.

## Interface
Parameters:
- `W`, 36: data-path word width; AD is `W+2` bits (two guard bits above bit 0).
- `STEPS`, 16: step-table depth (power of two, ≥2); `SA = $clog2(STEPS)`.
- `SETTLE`, 1: cycles between AR load and AD sample (≥1).
- `FW`, 6: AD function code width (CRAM.AD).

Ports:
- `eboxClk` in 1: EBOX clock; all state on posedge.
- `eboxReset_n` in 1: one clock; reset is asynchronous and active-low.
- `tblWe` in 1: write one table entry.
- `tblAdr` in SA: entry index.
- `tblCache` in W: word presented as cacheDataRead.
- `tblAdFunc` in FW: AD function for the step.
- `tblBrLoad` in 1: step also loads BR from AR (BR/AR).
- `tblCheck` in 1: compare AD this step.
- `tblExpect` in W+2: expected AD.
- `start` in 1: begin run (single-cycle pulse).
- `abort` in 1: terminate run.
- `lastStep` in SA: index of final step per pass.
- `passes` in 8: extra passes (0 = one pass).
- `edpAD` in W+2: AD from `edp`.
- `cacheDataRead` out W; `adFunc` out FW; `arLoad` out 1 (drives all three AR load enables); `brLoad` out 1.
- `busy` out 1; `done` out 1; `pass` out 1.
- `errCount` out 16; `firstFailStep` out SA; `firstFailAD` out W+2.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: outputs quiet; `start` latches `lastStep`/`passes`, clears `errCount`, `firstFail*`, `done`, sets step=0 → DRIVE.
- DRIVE (1 cycle): `cacheDataRead`=entry.cache, `adFunc`=entry.func, `arLoad`=1, `brLoad`=entry.brLoad → SETTLE.
- SETTLE (`SETTLE` cycles, down-counter): `cacheDataRead`/`adFunc` held, strobes 0 → CHECK.
- CHECK (1 cycle): if entry.check and `edpAD`≠entry.expect: `errCount`+=1 (saturates at 16'hFFFF); if first mismatch of run, capture step index and `edpAD`. Then: step<lastStep → step+1, DRIVE; else passes remaining>0 → decrement, step=0, DRIVE; else DONE.
- DONE: `done`=1, `pass`=(errCount==0); `busy`=0; holds until next `start` (→ as IDLE start).
- `abort` in any busy state → DONE next cycle, `pass`=0, counters retained; abort wins over `start` and over CHECK update in the same cycle (the CHECK comparison is discarded).
- `start` while busy: ignored. `tblWe` while busy: ignored (table immutable during run); `tblWe` in IDLE/DONE writes at posedge.
- Outputs are registered; no combinational path from `edpAD` to outputs.

## Timing
- Reset: state IDLE; all outputs 0 (`cacheDataRead`, `adFunc`, strobes, `busy`, `done`, `pass`, `errCount`, `firstFail*`); table contents undefined (not reset).
- `busy` rises the cycle after `start`.
- Per step: 2+SETTLE cycles; run length = (lastStep+1)·(passes+1)·(2+SETTLE) cycles, then `done` one cycle later.
- AR loads at the posedge ending DRIVE; AD sampled at the posedge ending CHECK.
- lastStep=0: single-step passes. Step counter never exceeds lastStep; no wrap beyond STEPS-1.
- Reset asserted mid-run: immediate return to reset values; deassertion does not restart the run.

## Structure
- Shared package `edp_seq_pkg`: state enum `tEdpSeqState`, step-entry struct `tEdpStep` (cache, func, brLoad, check, expect), AD function code constants reused from CRAM definitions.
- One sub-module: `edp_step_ram` (STEPS×entry, sync write, async read), inferred as distributed RAM.

## Test plan
- Load 1 step cache=36'h555555555, func=AD/A, check, expect=38'h0555555555, SETTLE=1, start → `done` after 4 cycles, `pass`=1, errCount=0.
- 3 steps: AR=123456789 with brLoad; AR=987654321; AD/A+B expect 38'h0AAAAAAAAA → pass=1; corrupt expect → errCount=1, firstFailStep=2, firstFailAD=38'h0AAAAAAAAA.
- lastStep=3, passes=2, one bad step → errCount=3, run exactly 36 cycles with SETTLE=1.
- `abort` in SETTLE of step 1 → `done`=1, `pass`=0 next cycle, no further `arLoad`.
- `start` and `abort` same cycle while busy; `tblWe` while busy → abort honoured, table unchanged (verified by rerun).
- `eboxReset_n` low mid-CHECK → all outputs 0 asynchronously; after release stays IDLE until `start`.

Source files
------------

// File: rtl/edp_seq_pkg.sv
// Shared types and constants for the EDP micro-step sequencer.
// Holds the FSM state enum, the step-table entry layout and the CRAM AD function codes.
package edp_seq_pkg;

    localparam int EDP_W  = 36;
    localparam int EDP_FW = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } tEdpSeqState;

    // Entry layout at the default widths; instances with other widths use the same field order
    typedef struct packed {
        logic [EDP_W-1:0]  cache;
        logic [EDP_FW-1:0] func;
        logic              brLoad;
        logic              check;
        logic [EDP_W+1:0]  expectAD;
    } tEdpStep;

    localparam logic [EDP_FW-1:0] AD_A_PLUS_B = 6'o06;
    localparam logic [EDP_FW-1:0] AD_A        = 6'o25;
    localparam logic [EDP_FW-1:0] AD_B        = 6'o26;
    localparam logic [EDP_FW-1:0] AD_ZERO     = 6'o23;

endpackage

// File: rtl/edp_step_ram.sv
// Step-table storage: synchronous write, asynchronous read.
// Small enough to map onto distributed RAM; contents are deliberately not reset.
module edp_step_ram
    import edp_seq_pkg::*;
#(
    parameter int EW    = $bits(tEdpStep),
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_adr,
    input  logic [EW-1:0] wr_data,
    input  logic [AW-1:0] rd_adr,
    output logic [EW-1:0] rd_data
);

    logic [EW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_adr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_adr];

endmodule

// File: rtl/edp_step_seq.sv
// Replays a table of EBOX data-path steps into the EDP and checks each AD result.
// Every output is registered; edpAD only reaches the error counters and capture registers.
module edp_step_seq
    import edp_seq_pkg::*;
#(
    parameter int W      = 36,
    parameter int STEPS  = 16,
    parameter int SA     = $clog2(STEPS),
    parameter int SETTLE = 1,
    parameter int FW     = 6
) (
    input  logic          eboxClk,
    input  logic          eboxReset_n,
    input  logic          tblWe,
    input  logic [SA-1:0] tblAdr,
    input  logic [W-1:0]  tblCache,
    input  logic [FW-1:0] tblAdFunc,
    input  logic          tblBrLoad,
    input  logic          tblCheck,
    input  logic [W+1:0]  tblExpect,
    input  logic          start,
    input  logic          abort,
    input  logic [SA-1:0] lastStep,
    input  logic [7:0]    passes,
    input  logic [W+1:0]  edpAD,
    output logic [W-1:0]  cacheDataRead,
    output logic [FW-1:0] adFunc,
    output logic          arLoad,
    output logic          brLoad,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [15:0]   errCount,
    output logic [SA-1:0] firstFailStep,
    output logic [W+1:0]  firstFailAD
);

    // Same field order as tEdpStep, sized by this instance's parameters
    typedef struct packed {
        logic [W-1:0]  cache;
        logic [FW-1:0] func;
        logic          brLoad;
        logic          check;
        logic [W+1:0]  expectAD;
    } step_t;

    localparam int EW = $bits(step_t);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    tEdpSeqState   state, next_state;
    logic [SA-1:0] step, next_step;
    logic [SA-1:0] last_q, next_last;
    logic [7:0]    passes_left, next_passes;
    logic [CW-1:0] cnt, next_cnt;
    logic          cur_check, next_check;
    logic [W+1:0]  cur_expect, next_expect;

    logic [W-1:0]  next_cache;
    logic [FW-1:0] next_func;
    logic          next_ar, next_br, next_busy, next_done, next_pass;
    logic [15:0]   next_err;
    logic [SA-1:0] next_ffs;
    logic [W+1:0]  next_ffad;

    logic          load_step;
    logic          run_state;
    logic [SA-1:0] rd_adr;
    logic [EW-1:0] rd_bits;
    step_t         rd_entry;
    step_t         wr_entry;

    assign run_state = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);

    assign wr_entry = '{cache: tblCache, func: tblAdFunc, brLoad: tblBrLoad,
                        check: tblCheck, expectAD: tblExpect};
    assign rd_entry = step_t'(rd_bits);

    edp_step_ram #(
        .EW    (EW),
        .DEPTH (STEPS),
        .AW    (SA)
    ) u_ram (
        .clk     (eboxClk),
        .we      (tblWe && !run_state),
        .wr_adr  (tblAdr),
        .wr_data (wr_entry),
        .rd_adr  (rd_adr),
        .rd_data (rd_bits)
    );

    always_comb begin
        next_state  = state;
        next_step   = step;
        next_last   = last_q;
        next_passes = passes_left;
        next_cnt    = cnt;
        next_check  = cur_check;
        next_expect = cur_expect;
        next_cache  = cacheDataRead;
        next_func   = adFunc;
        next_ar     = 1'b0;
        next_br     = 1'b0;
        next_done   = done;
        next_pass   = pass;
        next_err    = errCount;
        next_ffs    = firstFailStep;
        next_ffad   = firstFailAD;
        load_step   = 1'b0;
        rd_adr      = step;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_step   = '0;
                    next_last   = lastStep;
                    next_passes = passes;
                    next_err    = '0;
                    next_ffs    = '0;
                    next_ffad   = '0;
                    next_done   = 1'b0;
                    next_pass   = 1'b0;
                    load_step   = 1'b1;
                    rd_adr      = '0;
                end
            end
            S_DRIVE: begin
                next_state = S_SETTLE;
                next_cnt   = CW'(SETTLE - 1);
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    next_state = S_CHECK;
                end else begin
                    next_cnt = cnt - CW'(1);
                end
            end
            S_CHECK: begin
                // errCount still zero means this is the first mismatch of the run
                if (cur_check && (edpAD != cur_expect)) begin
                    if (errCount != 16'hFFFF) begin
                        next_err = errCount + 16'd1;
                    end
                    if (errCount == 16'd0) begin
                        next_ffs  = step;
                        next_ffad = edpAD;
                    end
                end
                if (step < last_q) begin
                    next_step = step + SA'(1);
                    rd_adr    = step + SA'(1);
                    load_step = 1'b1;
                end else if (passes_left != 8'd0) begin
                    next_passes = passes_left - 8'd1;
                    next_step   = '0;
                    rd_adr      = '0;
                    load_step   = 1'b1;
                end else begin
                    next_state = S_DONE;
                    next_done  = 1'b1;
                    next_pass  = (next_err == 16'd0);
                end
            end
            default: next_state = S_IDLE;
        endcase

        if (load_step) begin
            next_state  = S_DRIVE;
            next_check  = rd_entry.check;
            next_expect = rd_entry.expectAD;
            next_cache  = rd_entry.cache;
            next_func   = rd_entry.func;
            next_ar     = 1'b1;
            next_br     = rd_entry.brLoad;
        end

        // Abort discards whatever the current state would have done this cycle
        if (abort && run_state) begin
            next_state  = S_DONE;
            next_step   = step;
            next_passes = passes_left;
            next_err    = errCount;
            next_ffs    = firstFailStep;
            next_ffad   = firstFailAD;
            next_ar     = 1'b0;
            next_br     = 1'b0;
            next_done   = 1'b1;
            next_pass   = 1'b0;
        end

        if ((next_state == S_IDLE) || (next_state == S_DONE)) begin
            next_cache = '0;
            next_func  = '0;
        end

        next_busy = (next_state == S_DRIVE) || (next_state == S_SETTLE) || (next_state == S_CHECK);
    end

    always_ff @(posedge eboxClk or negedge eboxReset_n) begin
        if (!eboxReset_n) begin
            state         <= S_IDLE;
            step          <= '0;
            last_q        <= '0;
            passes_left   <= '0;
            cnt           <= '0;
            cur_check     <= 1'b0;
            cur_expect    <= '0;
            cacheDataRead <= '0;
            adFunc        <= '0;
            arLoad        <= 1'b0;
            brLoad        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            errCount      <= '0;
            firstFailStep <= '0;
            firstFailAD   <= '0;
        end else begin
            state         <= next_state;
            step          <= next_step;
            last_q        <= next_last;
            passes_left   <= next_passes;
            cnt           <= next_cnt;
            cur_check     <= next_check;
            cur_expect    <= next_expect;
            cacheDataRead <= next_cache;
            adFunc        <= next_func;
            arLoad        <= next_ar;
            brLoad        <= next_br;
            busy          <= next_busy;
            done          <= next_done;
            pass          <= next_pass;
            errCount      <= next_err;
            firstFailStep <= next_ffs;
            firstFailAD   <= next_ffad;
        end
    end

endmodule

// File: tb/tb_edp_step_seq.sv
// Directed bench for edp_step_seq with a tiny AR/BR/AD model standing in for the EDP.
// Expected values are hand-computed constants; each comparison is an immediate assertion.
module tb_edp_step_seq;
    import edp_seq_pkg::*;

    localparam int W      = 36;
    localparam int STEPS  = 16;
    localparam int SA     = 4;
    localparam int SETTLE = 1;
    localparam int FW     = 6;

    logic          eboxClk = 1'b0;
    logic          eboxReset_n;
    logic          tblWe;
    logic [SA-1:0] tblAdr;
    logic [W-1:0]  tblCache;
    logic [FW-1:0] tblAdFunc;
    logic          tblBrLoad;
    logic          tblCheck;
    logic [W+1:0]  tblExpect;
    logic          start;
    logic          abort;
    logic [SA-1:0] lastStep;
    logic [7:0]    passes;
    logic [W+1:0]  edpAD;
    logic [W-1:0]  cacheDataRead;
    logic [FW-1:0] adFunc;
    logic          arLoad;
    logic          brLoad;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   errCount;
    logic [SA-1:0] firstFailStep;
    logic [W+1:0]  firstFailAD;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] ar = '0;
    logic [W-1:0] br = '0;

    edp_step_seq #(
        .W(W), .STEPS(STEPS), .SA(SA), .SETTLE(SETTLE), .FW(FW)
    ) dut (
        .eboxClk(eboxClk), .eboxReset_n(eboxReset_n),
        .tblWe(tblWe), .tblAdr(tblAdr), .tblCache(tblCache), .tblAdFunc(tblAdFunc),
        .tblBrLoad(tblBrLoad), .tblCheck(tblCheck), .tblExpect(tblExpect),
        .start(start), .abort(abort), .lastStep(lastStep), .passes(passes),
        .edpAD(edpAD), .cacheDataRead(cacheDataRead), .adFunc(adFunc),
        .arLoad(arLoad), .brLoad(brLoad), .busy(busy), .done(done), .pass(pass),
        .errCount(errCount), .firstFailStep(firstFailStep), .firstFailAD(firstFailAD)
    );

    always #5 eboxClk = ~eboxClk;

    // Minimal EDP: AR loads from the cache word, BR/AR copies the old AR on the same edge
    always @(posedge eboxClk) begin
        if (arLoad) begin
            ar <= cacheDataRead;
            if (brLoad) br <= ar;
        end
    end

    assign edpAD = (adFunc == AD_A_PLUS_B) ? ({2'b00, ar} + {2'b00, br}) : {2'b00, ar};

    task automatic tick();
        @(posedge eboxClk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic writeEntry(input logic [SA-1:0] adr, input logic [W-1:0] cache,
                              input logic [FW-1:0] func, input logic brl, input logic chk,
                              input logic [W+1:0] expv);
        tblWe = 1'b1; tblAdr = adr; tblCache = cache; tblAdFunc = func;
        tblBrLoad = brl; tblCheck = chk; tblExpect = expv;
        tick();
        tblWe = 1'b0;
    endtask

    task automatic applyStimulus(input logic [SA-1:0] last, input logic [7:0] npasses);
        lastStep = last; passes = npasses; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, output int cycles);
        cycles = 0;
        while (!done && cycles < maxCycles) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int nBusy;
        int nAr;

        eboxReset_n = 1'b0; tblWe = 1'b0; tblAdr = '0; tblCache = '0; tblAdFunc = '0;
        tblBrLoad = 1'b0; tblCheck = 1'b0; tblExpect = '0; start = 1'b0; abort = 1'b0;
        lastStep = '0; passes = '0;
        tick(); tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err", errCount, 0);
        checkOutput("rst_cache", cacheDataRead, 0);
        checkOutput("rst_arload", arLoad, 0);
        checkOutput("rst_ffad", firstFailAD, 0);
        eboxReset_n = 1'b1;
        tick();

        $display("[TB] single step AD/A");
        writeEntry(0, 36'h555555555, AD_A, 1'b0, 1'b1, 38'h0555555555);
        applyStimulus(0, 0);
        checkOutput("t1_busy", busy, 1);
        checkOutput("t1_arload", arLoad, 1);
        checkOutput("t1_cache", cacheDataRead, 36'h555555555);
        checkOutput("t1_func", adFunc, AD_A);
        tick(); tick();
        checkOutput("t1_done_early", done, 0);
        tick();
        checkOutput("t1_done", done, 1);
        checkOutput("t1_pass", pass, 1);
        checkOutput("t1_err", errCount, 0);
        checkOutput("t1_busy_end", busy, 0);

        $display("[TB] three step A+B");
        writeEntry(0, 36'h123456789, AD_A, 1'b0, 1'b0, 38'h0);
        writeEntry(1, 36'h987654321, AD_A, 1'b1, 1'b0, 38'h0);
        writeEntry(2, 36'h987654321, AD_A_PLUS_B, 1'b0, 1'b1, 38'h0AAAAAAAAA);
        applyStimulus(2, 0);
        waitDone(40, cyc);
        checkOutput("t2_cycles", cyc, 9);
        checkOutput("t2_pass", pass, 1);
        checkOutput("t2_err", errCount, 0);

        writeEntry(2, 36'h987654321, AD_A_PLUS_B, 1'b0, 1'b1, 38'h0AAAAAAAAB);
        applyStimulus(2, 0);
        waitDone(40, cyc);
        checkOutput("t2b_done", done, 1);
        checkOutput("t2b_pass", pass, 0);
        checkOutput("t2b_err", errCount, 1);
        checkOutput("t2b_ffstep", firstFailStep, 2);
        checkOutput("t2b_ffad", firstFailAD, 38'h0AAAAAAAAA);

        $display("[TB] four steps, three passes");
        writeEntry(3, 36'h000000001, AD_A, 1'b0, 1'b1, 38'h0000000001);
        applyStimulus(3, 2);
        nBusy = 0;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (busy) nBusy++;
            tick();
            cyc++;
        end
        checkOutput("t3_done", done, 1);
        checkOutput("t3_busy_cycles", nBusy, 36);
        checkOutput("t3_err", errCount, 3);
        checkOutput("t3_ffstep", firstFailStep, 2);
        checkOutput("t3_ffad", firstFailAD, 38'h0AAAAAAAAA);

        $display("[TB] abort in settle of step 1");
        writeEntry(2, 36'h987654321, AD_A_PLUS_B, 1'b0, 1'b1, 38'h0AAAAAAAAA);
        applyStimulus(2, 0);
        tick(); tick(); tick(); tick();
        checkOutput("t4_settle_arload", arLoad, 0);
        checkOutput("t4_settle_cache", cacheDataRead, 36'h987654321);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("t4_done", done, 1);
        checkOutput("t4_pass", pass, 0);
        checkOutput("t4_busy", busy, 0);
        nAr = 0;
        for (int i = 0; i < 10; i++) begin
            if (arLoad) nAr++;
            tick();
        end
        checkOutput("t4_no_arload", nAr, 0);

        $display("[TB] start+abort and table write while busy");
        applyStimulus(2, 0);
        tblWe = 1'b1; tblAdr = 2; tblCache = 36'h0; tblAdFunc = AD_A;
        tblBrLoad = 1'b0; tblCheck = 1'b1; tblExpect = 38'h3FFFFFFFFF;
        tick();
        tblWe = 1'b0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checkOutput("t5_done", done, 1);
        checkOutput("t5_pass", pass, 0);
        checkOutput("t5_busy", busy, 0);
        tick();
        checkOutput("t5_no_restart", busy, 0);
        applyStimulus(2, 0);
        waitDone(40, cyc);
        checkOutput("t5_rerun_pass", pass, 1);
        checkOutput("t5_rerun_err", errCount, 0);

        $display("[TB] reset during check");
        applyStimulus(2, 0);
        tick(); tick();
        checkOutput("t6_busy_before", busy, 1);
        #2;
        eboxReset_n = 1'b0;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_cache", cacheDataRead, 0);
        checkOutput("t6_func", adFunc, 0);
        #3;
        eboxReset_n = 1'b1;
        nBusy = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy || done || arLoad) nBusy++;
        end
        checkOutput("t6_stays_idle", nBusy, 0);
        applyStimulus(2, 0);
        waitDone(40, cyc);
        checkOutput("t6_restart_pass", pass, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
